// File: rtl/bignum_pkg.sv
// Shared widths, word/index types and state encoding for the word-serial bignum adder.
package bignum_pkg;

    localparam int unsigned WORD_W = 16;
    localparam int unsigned WORDS  = 64;
    localparam int unsigned CNT_W  = $clog2(WORDS);

    typedef logic [WORD_W-1:0] word_t;
    typedef logic [CNT_W-1:0]  idx_t;

    typedef enum logic {IDLE, RUN} state_t;

endpackage

// File: rtl/cla16_slice.sv
// Combinational 16-bit carry-lookahead adder slice: four 4-bit groups with group-level lookahead.
module cla16_slice
    import bignum_pkg::*;
(
    input  word_t a,
    input  word_t b,
    input  logic  ci,
    output word_t sum,
    output logic  co
);

    word_t      w_g;
    word_t      w_p;
    word_t      w_c;
    logic [3:0] w_gg;
    logic [3:0] w_gp;
    logic [4:0] w_gc;

    always_comb begin
        w_g  = a & b;
        w_p  = a ^ b;
        w_gg = '0;
        w_gp = '0;
        w_gc = '0;
        w_c  = '0;
        for (int k = 0; k < 4; k++) begin
            w_gg[k] = w_g[4*k+3]
                    | (w_p[4*k+3] & w_g[4*k+2])
                    | (w_p[4*k+3] & w_p[4*k+2] & w_g[4*k+1])
                    | ((&w_p[4*k+1 +: 3]) & w_g[4*k]);
            w_gp[k] = &w_p[4*k +: 4];
        end
        w_gc[0] = ci;
        for (int k = 0; k < 4; k++) begin
            w_gc[k+1] = w_gg[k] | (w_gp[k] & w_gc[k]);
        end
        // Bit carries inside each group start from that group's lookahead carry
        for (int k = 0; k < 4; k++) begin
            w_c[4*k] = w_gc[k];
            for (int j = 0; j < 3; j++) begin
                w_c[4*k+j+1] = w_g[4*k+j] | (w_p[4*k+j] & w_c[4*k+j]);
            end
        end
        sum = w_p ^ w_c;
        co  = w_gc[4];
    end

endmodule

// File: rtl/word_serial_bignum_adder.sv
// Word-serial multi-word adder, LS word first, carry chained between beats.
// Optional subtract mode (A + ~B + 1) when BIGNUM_ADDER_SUB_EN is defined.
module word_serial_bignum_adder
    import bignum_pkg::*;
#(
    parameter int unsigned WORDS_P = WORDS,
    localparam int unsigned IDX_W  = $clog2(WORDS_P)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  word_t            in_a,
    input  word_t            in_b,
    input  logic             in_cin,
`ifdef BIGNUM_ADDER_SUB_EN
    input  logic             in_sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output word_t            out_sum,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             out_cout,
    output logic             busy
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_P - 1);

    state_t           r_state;
    logic [IDX_W-1:0] r_idx;
    logic             r_carry;
    logic             r_out_valid;
    word_t            r_out_sum;
    logic [IDX_W-1:0] r_out_idx;
    logic             r_out_last;
    logic             r_out_cout;

    logic  w_in_fire;
    logic  w_out_fire;
    logic  w_first;
    logic  w_last;
    logic  w_ci;
    word_t w_b;
    word_t w_sum;
    logic  w_co;

`ifdef BIGNUM_ADDER_SUB_EN
    logic r_sub;
    logic w_sub;
`endif

    assign in_ready   = !r_out_valid | out_ready;
    assign w_in_fire  = in_valid & in_ready;
    assign w_out_fire = r_out_valid & out_ready;
    assign w_first    = (r_idx == '0);
    assign w_last     = (r_idx == LAST_IDX);

    always_comb begin
`ifdef BIGNUM_ADDER_SUB_EN
        // Mode is latched on word 0; later changes of in_sub are ignored
        w_sub = w_first ? in_sub : r_sub;
        w_b   = w_sub ? ~in_b : in_b;
        w_ci  = w_first ? (in_sub | in_cin) : r_carry;
`else
        w_b   = in_b;
        w_ci  = w_first ? in_cin : r_carry;
`endif
    end

    cla16_slice u_slice (
        .a   (in_a),
        .b   (w_b),
        .ci  (w_ci),
        .sum (w_sum),
        .co  (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_idx       <= '0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_idx   <= '0;
            r_out_last  <= 1'b0;
            r_out_cout  <= 1'b0;
`ifdef BIGNUM_ADDER_SUB_EN
            r_sub       <= 1'b0;
`endif
        end else if (w_in_fire) begin
            r_out_valid <= 1'b1;
            r_out_sum   <= w_sum;
            r_out_idx   <= r_idx;
            r_out_last  <= w_last;
            r_out_cout  <= w_last & w_co;
            r_carry     <= !w_last & w_co;
            r_idx       <= w_last ? '0 : r_idx + 1'b1;
            r_state     <= w_last ? IDLE : RUN;
`ifdef BIGNUM_ADDER_SUB_EN
            r_sub       <= w_sub;
`endif
        end else if (w_out_fire) begin
            r_out_valid <= 1'b0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_sum   = r_out_sum;
    assign out_idx   = r_out_idx;
    assign out_last  = r_out_last;
    assign out_cout  = r_out_cout;
    assign busy      = (r_state == RUN);

endmodule

// File: tb/tb_word_serial_bignum_adder.sv
// Self-checking bench for word_serial_bignum_adder; reference is whole-operand arithmetic.
module tb_word_serial_bignum_adder;

    localparam int WW  = 16;
    localparam int NW  = 64;
    localparam int TOT = WW * NW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [WW-1:0] in_a;
    logic [WW-1:0] in_b;
    logic          in_cin;
`ifdef BIGNUM_ADDER_SUB_EN
    logic          in_sub;
`endif
    logic          out_valid;
    logic          out_ready;
    logic [WW-1:0] out_sum;
    logic [5:0]    out_idx;
    logic          out_last;
    logic          out_cout;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [TOT-1:0] op_a [4];
    logic [TOT-1:0] op_b [4];
    logic           op_cin [4];
    logic           op_sub [4];

    always #5 clk = ~clk;

    word_serial_bignum_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
`ifdef BIGNUM_ADDER_SUB_EN
        .in_sub    (in_sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"}, 32'(out_valid), 32'd0);
        check({tag, "_out_sum"},   32'(out_sum),   32'd0);
        check({tag, "_out_idx"},   32'(out_idx),   32'd0);
        check({tag, "_out_last"},  32'(out_last),  32'd0);
        check({tag, "_out_cout"},  32'(out_cout),  32'd0);
        check({tag, "_busy"},      32'(busy),      32'd0);
    endtask

    // Streams nops operands with random stalls; checks each output word against the full-width sum.
    task automatic run_ops(input int nops, input int in_pct, input int out_pct, input string tag,
                           output int first_fire, output int last_fire);
        logic [TOT:0]  refs [4];
        int            total;
        int            sent;
        int            rcvd;
        int            cyc;
        int            w;
        int            o;
        logic          hold;
        logic [WW-1:0] h_sum;
        logic [5:0]    h_idx;
        logic          h_last;
        logic          h_cout;
        total      = nops * NW;
        sent       = 0;
        rcvd       = 0;
        cyc        = 0;
        hold       = 1'b0;
        first_fire = -1;
        last_fire  = -1;
        for (int i = 0; i < nops; i++) begin
            if (op_sub[i])
                refs[i] = {1'b0, op_a[i]} + {1'b0, ~op_b[i]} + (TOT+1)'(1);
            else
                refs[i] = {1'b0, op_a[i]} + {1'b0, op_b[i]} + (TOT+1)'(op_cin[i]);
        end
        while (rcvd < total && cyc < 2000) begin
            @(negedge clk);
            if (hold) begin
                check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
                check({tag, "_hold_sum"},   32'(out_sum),   32'(h_sum));
                check({tag, "_hold_idx"},   32'(out_idx),   32'(h_idx));
                check({tag, "_hold_last"},  32'(out_last),  32'(h_last));
                check({tag, "_hold_cout"},  32'(out_cout),  32'(h_cout));
            end
            if (sent < total) begin
                w        = sent % NW;
                o        = sent / NW;
                in_valid = ($urandom_range(99) >= in_pct);
                in_a     = op_a[o][w*WW +: WW];
                in_b     = op_b[o][w*WW +: WW];
                in_cin   = (w == 0) ? op_cin[o] : 1'($urandom_range(1));
`ifdef BIGNUM_ADDER_SUB_EN
                in_sub   = (w == 0) ? op_sub[o] : 1'($urandom_range(1));
`endif
            end else begin
                in_valid = 1'b0;
                in_a     = WW'($urandom);
                in_b     = WW'($urandom);
            end
            out_ready = ($urandom_range(99) >= out_pct);
            #1;
            if (out_valid && out_ready) begin
                w = rcvd % NW;
                o = rcvd / NW;
                check({tag, "_sum"},  32'(out_sum),  32'(refs[o][w*WW +: WW]));
                check({tag, "_idx"},  32'(out_idx),  32'(w));
                check({tag, "_last"}, 32'(out_last), 32'(w == NW - 1));
                check({tag, "_cout"}, 32'(out_cout), (w == NW - 1) ? 32'(refs[o][TOT]) : 32'd0);
                if (first_fire < 0) first_fire = cyc;
                last_fire = cyc;
                rcvd++;
            end
            if (out_valid && !out_ready)
                check({tag, "_stall_in_ready"}, 32'(in_ready), 32'd0);
            hold   = out_valid && !out_ready;
            h_sum  = out_sum;
            h_idx  = out_idx;
            h_last = out_last;
            h_cout = out_cout;
            if (in_valid && in_ready) sent++;
            cyc++;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check({tag, "_words_received"}, 32'(rcvd), 32'(total));
    endtask

    initial begin
        int ff;
        int lf;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_cin    = 1'b0;
        out_ready = 1'b0;
`ifdef BIGNUM_ADDER_SUB_EN
        in_sub    = 1'b0;
`endif
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0; op_b[i] = '0; op_cin[i] = 1'b0; op_sub[i] = 1'b0;
        end
        #12;
        check_reset_outputs("reset");
        check("reset_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;

        // All-ones plus carry-in ripples through every word
        op_a[0] = '1; op_b[0] = '0; op_cin[0] = 1'b1;
        run_ops(1, 0, 0, "ones", ff, lf);
        check("ones_carry_cleared", 32'(dut.r_carry), 32'd0);
        check("ones_idle", 32'(busy), 32'd0);

        // Back-to-back operands, no stalls
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < NW; k++) begin
                op_a[i][k*WW +: WW] = WW'(k);
                op_b[i][k*WW +: WW] = WW'(1);
            end
            op_cin[i] = 1'b0;
        end
        run_ops(2, 0, 0, "b2b", ff, lf);
        check("b2b_consecutive", 32'(lf - ff), 32'd127);

        // Random operands with stalls on both sides
        for (int i = 0; i < 3; i++) begin
            for (int k = 0; k < TOT / 32; k++) begin
                op_a[i][k*32 +: 32] = $urandom;
                op_b[i][k*32 +: 32] = $urandom;
            end
            op_cin[i] = 1'($urandom_range(1));
        end
        op_a[2] = '1;
        run_ops(3, 30, 30, "rand", ff, lf);

        // Partial operand, then asynchronous reset mid-operand
        out_ready = 1'b1;
        for (int k = 0; k <= 20; k++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_a     = 16'hffff;
            in_b     = 16'hffff;
            in_cin   = 1'b1;
        end
        @(negedge clk);
        in_valid = 1'b0;
        check("partial_busy", 32'(busy), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        op_a[0] = {NW{16'h8000}}; op_b[0] = {NW{16'h8000}}; op_cin[0] = 1'b0;
        run_ops(1, 10, 10, "after_reset", ff, lf);

`ifdef BIGNUM_ADDER_SUB_EN
        op_sub[0] = 1'b1; op_sub[1] = 1'b1;
        op_a[0] = TOT'(5); op_b[0] = TOT'(7); op_cin[0] = 1'b0;
        op_a[1] = TOT'(7); op_b[1] = TOT'(5); op_cin[1] = 1'b0;
        run_ops(2, 20, 20, "sub", ff, lf);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
